// File: rtl/fp_mul_accumulator.sv
// ============================================================================
// Module  : fp_mul_accumulator
// Brief   : Streaming FP32 packet accumulator, 4-cycle FSM adder, valid/ready I/O.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_accumulator #(
  parameter int N     = 32,
  parameter int E     = 8,
  parameter int MA    = 23,
  parameter int BIAS  = 127,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int SW  = MA + 1;
  localparam int FW  = SW + 3;
  localparam int LZW = $clog2(FW + 1);
  localparam logic signed [E+1:0] EXP_MAX = (E+2)'(2 * BIAS);
  localparam logic signed [E+1:0] EXP_ONE = (E+2)'(1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDN, S_ROUND, S_OUT} state_t;
  state_t r_state, w_next;

  logic [N-1:0]           r_acc, r_in;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_last, r_sub, r_sign, r_zsign, r_zero, r_inf;
  logic [FW-1:0]          r_big_sig, r_sml_sig, r_sig;
  logic signed [E+1:0]    r_exp;

  // Alignment: zero operands (exp==0) take magnitude 0 so they always sort low.
  logic            w_a_zero, w_b_zero, w_a_big, w_big_z, w_sml_z;
  logic [N-2:0]    w_a_mag, w_b_mag;
  logic [N-1:0]    w_big, w_sml;
  logic [FW-1:0]   w_big_sig, w_sml_sig, w_aligned;
  logic [E-1:0]    w_diff, w_shamt;
  logic [2*FW-1:0] w_wide;

  assign w_a_zero  = (r_acc[N-2:MA] == '0);
  assign w_b_zero  = (r_in[N-2:MA] == '0);
  assign w_a_mag   = w_a_zero ? '0 : r_acc[N-2:0];
  assign w_b_mag   = w_b_zero ? '0 : r_in[N-2:0];
  assign w_a_big   = (w_a_mag >= w_b_mag);
  assign w_big     = w_a_big ? r_acc : r_in;
  assign w_sml     = w_a_big ? r_in : r_acc;
  assign w_big_z   = w_a_big ? w_a_zero : w_b_zero;
  assign w_sml_z   = w_a_big ? w_b_zero : w_a_zero;
  assign w_big_sig = w_big_z ? '0 : {1'b1, w_big[MA-1:0], 3'b000};
  assign w_sml_sig = w_sml_z ? '0 : {1'b1, w_sml[MA-1:0], 3'b000};
  assign w_diff    = w_big[N-2:MA] - w_sml[N-2:MA];
  assign w_shamt   = (w_diff > E'(FW)) ? E'(FW) : w_diff;
  assign w_wide    = {w_sml_sig, {FW{1'b0}}} >> w_shamt;
  assign w_aligned = {w_wide[2*FW-1:FW+1], w_wide[FW] | (|w_wide[FW-1:0])};

  function automatic logic [LZW-1:0] f_lzc(input logic [FW-1:0] v);
    f_lzc = LZW'(FW);
    for (int i = 0; i < FW; i++) begin
      if (v[i]) f_lzc = LZW'(FW - 1 - i);
    end
  endfunction

  logic [FW:0]         w_sum;
  logic                w_sum_zero;
  logic [LZW-1:0]      w_lzc;
  logic [FW-1:0]       w_norm;
  logic signed [E+1:0] w_nexp;

  assign w_sum      = r_sub ? ({1'b0, r_big_sig} - {1'b0, r_sml_sig})
                            : ({1'b0, r_big_sig} + {1'b0, r_sml_sig});
  assign w_sum_zero = (w_sum == '0);
  assign w_lzc      = f_lzc(w_sum[FW-1:0]);

  always_comb begin
    w_norm = w_sum[FW-1:0] << w_lzc;
    w_nexp = r_exp - $signed({{(E+2-LZW){1'b0}}, w_lzc});
    if (w_sum[FW]) begin
      w_norm = {w_sum[FW:2], w_sum[1] | w_sum[0]};
      w_nexp = r_exp + EXP_ONE;
    end
  end

  // Round to nearest even on the G/R/S bits below the 24-bit significand.
  logic                w_inc;
  logic [SW:0]         w_rnd;
  logic signed [E+1:0] w_rexp;
  logic [MA-1:0]       w_rman;
  logic [N-1:0]        w_result;

  assign w_inc  = r_sig[2] & (r_sig[1] | r_sig[0] | r_sig[3]);
  assign w_rnd  = {1'b0, r_sig[FW-1:3]} + {{SW{1'b0}}, w_inc};
  assign w_rexp = w_rnd[SW] ? (r_exp + EXP_ONE) : r_exp;
  assign w_rman = w_rnd[SW] ? w_rnd[MA:1] : w_rnd[MA-1:0];

  always_comb begin
    w_result = {r_sign, w_rexp[E-1:0], w_rman};
    if (r_inf)                  w_result = r_acc;
    else if (r_zero)            w_result = {r_sign, {(N-1){1'b0}}};
    else if (w_rexp > EXP_MAX)  w_result = {r_sign, {E{1'b1}}, {MA{1'b0}}};
    else if (w_rexp < EXP_ONE)  w_result = {r_sign, {(N-1){1'b0}}};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADDN;
      S_ADDN:  w_next = S_ROUND;
      S_ROUND: w_next = r_last ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign out_data  = out_valid ? r_acc : '0;
  assign out_count = out_valid ? r_cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_in      <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_sub     <= 1'b0;
      r_sign    <= 1'b0;
      r_zsign   <= 1'b0;
      r_zero    <= 1'b0;
      r_inf     <= 1'b0;
      r_big_sig <= '0;
      r_sml_sig <= '0;
      r_sig     <= '0;
      r_exp     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_in   <= in_data;
          r_last <= in_last;
          r_cnt  <= r_cnt + 1'b1;
        end
        S_ALIGN: begin
          r_sub     <= w_big[N-1] ^ w_sml[N-1];
          r_sign    <= w_big[N-1];
          r_zsign   <= w_a_zero & w_b_zero & r_acc[N-1] & r_in[N-1];
          r_inf     <= (r_acc[N-2:MA] == '1);
          r_big_sig <= w_big_sig;
          r_sml_sig <= w_aligned;
          r_exp     <= $signed({2'b00, w_big[N-2:MA]});
        end
        S_ADDN: begin
          r_sig  <= w_norm;
          r_exp  <= w_nexp;
          r_zero <= w_sum_zero;
          if (w_sum_zero) r_sign <= r_zsign;
        end
        S_ROUND: r_acc <= w_result;
        S_OUT: if (out_ready) begin
          r_acc <= '0;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_accumulator.sv
// ============================================================================
// Module  : tb_fp_mul_accumulator
// Brief   : Scoreboard bench for fp_mul_accumulator with exact-arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  fp_mul_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [31:0] data; logic [15:0] cnt; } exp_t;
  exp_t sb[$];

  logic [31:0] m_acc = 32'h0;
  logic [15:0] m_cnt = 16'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Exact sum on a wide integer grid, then a single correct round-to-nearest-even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic        za, zb, s;
    logic [31:0] big, sml;
    logic [65:0] vb, vs, m, q, rem, half;
    int          eb, es, d, p, sh, e;
    if (a[30:23] == 8'hFF) return a;
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    if (za && zb) return {a[31] & b[31], 31'h0};
    if (za) return b;
    if (zb) return a;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    eb = int'(big[30:23]);
    es = int'(sml[30:23]);
    d  = eb - es;
    vb = {42'h0, 1'b1, big[22:0]} << 40;
    vs = (d <= 40) ? ({42'h0, 1'b1, sml[22:0]} << (40 - d)) : 66'd1;
    m  = (big[31] == sml[31]) ? vb + vs : vb - vs;
    if (m == 66'd0) return 32'h0;
    s = big[31];
    p = 0;
    for (int i = 0; i < 66; i++) if (m[i]) p = i;
    e    = eb + p - 63;
    sh   = p - 23;
    q    = m >> sh;
    rem  = m & ((66'd1 << sh) - 66'd1);
    half = 66'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 66'd1;
    if (q[24]) begin q = q >> 1; e = e + 1; end
    if (e > 254) return {s, 8'hFF, 23'h0};
    if (e < 1)   return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("out_data", 64'(out_data), 64'(x.data));
        check("out_count", 64'(out_count), 64'(x.cnt));
      end
    end
  end

  // exp_d[32] set forces a directed expected packet sum instead of the model's.
  task automatic send(input logic [31:0] d, input logic last, input logic [32:0] exp_d);
    int   k;
    exp_t x;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    m_acc    = ref_add(m_acc, d);
    m_cnt    = m_cnt + 16'd1;
    if (last) begin
      x.data = exp_d[32] ? exp_d[31:0] : m_acc;
      x.cnt  = m_cnt;
      sb.push_back(x);
      m_acc  = 32'h0;
      m_cnt  = 16'h0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_ready_busy", 64'(in_ready), 64'd0);
    end
    if (last) begin
      @(negedge clk);
      check("out_valid_lat", 64'(out_valid), 64'd1);
    end
  endtask

  localparam logic [32:0] MODEL = 33'h0;
  function automatic logic [32:0] X(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  initial begin
    exp_t snap;
    int   k, len;
    logic [31:0] r;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;

    send(32'h3F800000, 1'b0, MODEL); send(32'h40000000, 1'b1, X(32'h40400000));
    send(32'h3F800000, 1'b0, MODEL); send(32'hBF800000, 1'b1, X(32'h00000000));
    send(32'h40A00000, 1'b1, X(32'h40A00000));
    send(32'h3F800000, 1'b0, MODEL); send(32'h33800000, 1'b1, X(32'h3F800000));
    send(32'h3F800000, 1'b0, MODEL); send(32'h33C00000, 1'b1, X(32'h3F800001));
    send(32'h3F800001, 1'b0, MODEL); send(32'h33800000, 1'b1, X(32'h3F800002));
    send(32'h7F7FFFFF, 1'b0, MODEL); send(32'h7F7FFFFF, 1'b0, MODEL);
    send(32'hBF800000, 1'b1, X(32'h7F800000));
    send(32'h80000000, 1'b0, MODEL); send(32'h80000000, 1'b1, X(32'h00000000));
    send(32'h00400000, 1'b1, X(32'h00000000));

    // Backpressure: sum must hold while the consumer stalls.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h3F800000, 1'b0, MODEL); send(32'h40400000, 1'b1, X(32'h40800000));
    snap = sb[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'(snap.data));
      check("bp_count", 64'(out_count), 64'(snap.cnt));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);

    // Reset during ADDN of the second element aborts the packet.
    send(32'h3F800000, 1'b0, MODEL);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h40400000; in_last = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    m_acc = 32'h0; m_cnt = 16'h0;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;
    send(32'h40000000, 1'b1, X(32'h40000000));

    // Random packets, including near-cancelling pairs.
    for (int p = 0; p < 10; p++) begin
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        r = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
        send(r, 1'(i == len - 1), MODEL);
      end
    end
    for (int p = 0; p < 4; p++) begin
      r = {1'b0, 8'($urandom_range(120, 130)), 23'($urandom)};
      send(r, 1'b0, MODEL);
      send({1'b1, r[30:1], ~r[0]}, 1'b1, MODEL);
    end

    k = 0;
    while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
